// File: rtl/dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_port_arbiter
//
// Purpose:
//   Shares one read/write port of the dual-port SRAM model between two
//   requesters, for example the host register bus (requester 0) and the
//   correlator/tracking engine (requester 1) on port A of the channel-state
//   RAM. Address, control and write data of the granted requester are muxed
//   onto the RAM port combinationally, so the RAM samples them on the same
//   edge that completes the handshake. The RAM's read data is registered
//   inside the RAM and appears one cycle later. This block remembers who
//   issued the read and raises that requester's rvalid for that one cycle.
//
// Configuration macro:
//   DPRAM_ARB_FIXED_PRIO_EN
//     - defined:   requester 0 always wins contention. Requester 1 can starve.
//     - undefined: round-robin. On contention the requester that was not
//                  granted last wins.
//
// Ports:
//   clk, rst_b                      clock, asynchronous active-low reset
//   reqN_addr/rd/wr/wdata           requester N command (held until ready)
//   reqN_ready                      grant: the command completes this edge
//   reqN_rvalid/rdata               read return, one cycle after the grant
//   mem_addr/rd/wr/wdata            drive to the RAM port
//   mem_rdata                       RAM port read data (registered in RAM)
// -----------------------------------------------------------------------------
module dpram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_b,

    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_rd,
    input  logic                  req0_wr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_rd,
    input  logic                  req1_wr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Requester identifiers, used for last_grant and rd_owner.
    localparam logic GRANT_REQ0 = 1'b0;
    localparam logic GRANT_REQ1 = 1'b1;

    logic                  pend0_s;
    logic                  pend1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;

    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic                  mem_rd_s;
    logic                  mem_wr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    logic                  last_grant_d;
    logic                  last_grant_q;
    logic                  rd_pend_d;
    logic                  rd_pend_q;
    logic                  rd_owner_d;
    logic                  rd_owner_q;

    // Grant decision from the pending requests and the last winner.
    always_comb begin
        pend0_s = req0_rd | req0_wr;
        pend1_s = req1_rd | req1_wr;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (pend0_s && pend1_s) begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            // The host must never stall, so requester 0 always wins.
            gnt0_s = 1'b1;
`else
            // Alternate: the requester that did not win last time goes now.
            if (last_grant_q == GRANT_REQ1) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
`endif
        end else if (pend0_s) begin
            gnt0_s = 1'b1;
        end else if (pend1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // RAM port mux. rd together with wr is a write only, so mem_rd is
    // masked by wr. The port is driven to all zeros when nobody is granted.
    always_comb begin
        mem_addr_s  = {ADDR_WIDTH{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        if (gnt0_s) begin
            mem_addr_s  = req0_addr;
            mem_wdata_s = req0_wdata;
            mem_wr_s    = req0_wr;
            mem_rd_s    = req0_rd & ~req0_wr;
        end else if (gnt1_s) begin
            mem_addr_s  = req1_addr;
            mem_wdata_s = req1_wdata;
            mem_wr_s    = req1_wr;
            mem_rd_s    = req1_rd & ~req1_wr;
        end else begin
            mem_addr_s  = {ADDR_WIDTH{1'b0}};
            mem_wdata_s = {DATA_WIDTH{1'b0}};
            mem_rd_s    = 1'b0;
            mem_wr_s    = 1'b0;
        end
    end

    // Next state for the round-robin pointer and the read-return tracker.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0_s) begin
            last_grant_d = GRANT_REQ0;
        end else if (gnt1_s) begin
            last_grant_d = GRANT_REQ1;
        end else begin
            last_grant_d = last_grant_q;
        end

        // A read issued this cycle comes back from the RAM next cycle.
        rd_pend_d  = mem_rd_s;
        rd_owner_d = rd_owner_q;
        if (mem_rd_s) begin
            rd_owner_d = gnt1_s ? GRANT_REQ1 : GRANT_REQ0;
        end else begin
            rd_owner_d = rd_owner_q;
        end
    end

    // State flops. Reset discards any outstanding read, and last_grant=1
    // lets requester 0 win the first contention after reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_grant_q <= GRANT_REQ1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= GRANT_REQ0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign req0_ready  = gnt0_s;
    assign req1_ready  = gnt1_s;

    assign mem_addr    = mem_addr_s;
    assign mem_rd      = mem_rd_s;
    assign mem_wr      = mem_wr_s;
    assign mem_wdata   = mem_wdata_s;

    // Both requesters see the RAM data. Only the owner's rvalid qualifies it.
    assign req0_rvalid = rd_pend_q & (rd_owner_q == GRANT_REQ0);
    assign req1_rvalid = rd_pend_q & (rd_owner_q == GRANT_REQ1);
    assign req0_rdata  = mem_rdata;
    assign req1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_arbiter
//
// Self-checking bench for dpram_port_arbiter. A simple RAM with a registered
// read is attached to the mem_* port. A transaction-level reference model
// keeps its own memory image, the last winner and the expected read return.
// Each step drives the inputs one delay after the rising edge, checks the
// outputs on the falling edge, and then advances the model at the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_dpram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_b;
    logic [AW-1:0] req0_addr;
    logic          req0_rd;
    logic          req0_wr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready;
    logic          req0_rvalid;
    logic [DW-1:0] req0_rdata;
    logic [AW-1:0] req1_addr;
    logic          req1_rd;
    logic          req1_wr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready;
    logic          req1_rvalid;
    logic [DW-1:0] req1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req0_addr  (req0_addr),
        .req0_rd    (req0_rd),
        .req0_wr    (req0_wr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_rvalid(req0_rvalid),
        .req0_rdata (req0_rdata),
        .req1_addr  (req1_addr),
        .req1_rd    (req1_rd),
        .req1_wr    (req1_wr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_rvalid(req1_rvalid),
        .req1_rdata (req1_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to the arbiter: write on the edge, registered read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        else if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_last;     // last winner (0/1)
    bit            m_rv;       // a read return is expected this cycle
    int            m_rv_own;
    logic [DW-1:0] m_rv_data;
    bit            g0_seen;
    bit            g1_seen;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle: predict, check at the falling edge, then commit at the rising edge.
    task automatic step();
        bit p0, p1, w0, w1, wr, rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        p0 = req0_rd || req0_wr;
        p1 = req1_rd || req1_wr;
        w0 = 1'b0;
        w1 = 1'b0;
        if (p0 && p1) begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            w0 = 1'b1;
`else
            if (m_last == 1) w0 = 1'b1; else w1 = 1'b1;
`endif
        end else begin
            w0 = p0;
            w1 = p1;
        end
        a  = w0 ? req0_addr  : (w1 ? req1_addr  : '0);
        d  = w0 ? req0_wdata : (w1 ? req1_wdata : '0);
        wr = w0 ? req0_wr : (w1 ? req1_wr : 1'b0);
        rd = (w0 ? req0_rd : (w1 ? req1_rd : 1'b0)) && !wr;

        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, w0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, w1});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, wr});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, rd});
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, a});
        chk("mem_wdata", mem_wdata, d);
        chk("req0_rvalid", {31'd0, req0_rvalid}, {31'd0, (m_rv && m_rv_own == 0)});
        chk("req1_rvalid", {31'd0, req1_rvalid}, {31'd0, (m_rv && m_rv_own == 1)});
        if (m_rv) begin
            if (m_rv_own == 0) chk("req0_rdata", req0_rdata, m_rv_data);
            else               chk("req1_rdata", req1_rdata, m_rv_data);
        end

        @(posedge clk);
        #1;
        m_rv = rd;
        if (rd) begin
            m_rv_own  = w1 ? 1 : 0;
            m_rv_data = ref_mem[a];
        end
        if (wr) ref_mem[a] = d;
        if (w0) m_last = 0;
        else if (w1) m_last = 1;
        g0_seen = w0;
        g1_seen = w1;
    endtask

    task automatic set0(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_rd = rd; req0_wr = wr; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_rd = rd; req1_wr = wr; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'hA5000000 ^ i;
            ref_mem[i] = 32'hA5000000 ^ i;
        end
        mem_rdata = '0;
        m_last = 1;
        m_rv = 1'b0;
        m_rv_own = 0;
        m_rv_data = '0;
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        rst_b = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_rvalid", {31'd0, req0_rvalid}, 32'd0);
        chk("rst_req1_rvalid", {31'd0, req1_rvalid}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // req0 writes 0xDEADBEEF to 0x005, then reads it back.
        set0(1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
        step();
        set0(1'b1, 1'b0, 10'h005, 32'h0);
        step();
        set0(1'b0, 1'b0, '0, '0);
        step();
        chk("readback_model", m_rv_data, 32'hDEADBEEF);

        // Both requesters read continuously. Grants alternate.
        set0(1'b1, 1'b0, 10'h010, '0);
        set1(1'b1, 1'b0, 10'h020, '0);
        repeat (4) step();
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        step();

        // rd and wr together on req1: write only, then read back.
        set1(1'b1, 1'b1, 10'h030, 32'h12345678);
        step();
        set1(1'b1, 1'b0, 10'h030, '0);
        step();
        set1(1'b0, 1'b0, '0, '0);
        step();
        chk("rdwr_readback_model", m_rv_data, 32'h12345678);

        // Grant a read, then reset before the next edge. The read is discarded.
        set0(1'b1, 1'b0, 10'h005, '0);
        @(negedge clk);
        chk("pre_reset_ready", {31'd0, req0_ready}, 32'd1);
        rst_b = 1'b0;
        set0(1'b0, 1'b0, '0, '0);
        m_rv = 1'b0;
        m_last = 1;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        step();
        set0(1'b1, 1'b0, 10'h040, '0);
        set1(1'b1, 1'b0, 10'h041, '0);
        step();
        chk("post_reset_first_winner", {31'd0, g0_seen}, 32'd1);
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        step();

        // Random traffic. A requester keeps its command until it is granted.
        for (int n = 0; n < 300; n++) begin
            if (n == 0 || g0_seen) begin
                case ($urandom_range(0, 3))
                    0: set0(1'b0, 1'b0, '0, '0);
                    1: set0(1'b1, 1'b0, 10'($urandom_range(0, 15)), '0);
                    2: set0(1'b0, 1'b1, 10'($urandom_range(0, 15)), 32'($urandom));
                    default: set0(1'b1, 1'b1, 10'($urandom_range(0, 15)), 32'($urandom));
                endcase
            end
            if (n == 0 || g1_seen) begin
                case ($urandom_range(0, 3))
                    0: set1(1'b0, 1'b0, '0, '0);
                    1: set1(1'b1, 1'b0, 10'($urandom_range(0, 15)), '0);
                    2: set1(1'b0, 1'b1, 10'($urandom_range(0, 15)), 32'($urandom));
                    default: set1(1'b1, 1'b1, 10'($urandom_range(0, 15)), 32'($urandom));
                endcase
            end
            step();
        end
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
